// File: rtl/counter_checker_if.sv
// rtl/counter_checker_if.sv - observation bundle of an up/down loadable counter
interface counter_checker_if #(
    parameter int N = 5
);
    logic         dut_rst;
    logic         dut_load;
    logic         dut_en;
    logic         dut_up;
    logic [N-1:0] dut_D;
    logic [N-1:0] dut_Q;
    logic         dut_max_tick;
    logic         dut_min_tick;

    // counter side drives, checker side only observes
    modport master (
        output dut_rst, dut_load, dut_en, dut_up, dut_D,
        output dut_Q, dut_max_tick, dut_min_tick
    );
    modport slave (
        input dut_rst, dut_load, dut_en, dut_up, dut_D,
        input dut_Q, dut_max_tick, dut_min_tick
    );
endinterface

// File: rtl/counter_checker.sv
// rtl/counter_checker.sv - cycle-accurate reference model and comparator for an up/down counter
module counter_checker #(
    parameter int N           = 5,
    parameter int CW          = 8,
    parameter int STOP_ON_ERR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_checker_if.slave     obs,
    output logic                 synced,
    output logic                 err,
    output logic                 err_sticky,
    output logic [2:0]           err_code,
    output logic [CW-1:0]        err_count,
    output logic [N-1:0]         exp_q,
    output logic [N-1:0]         first_bad_q
);

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        TRACK  = 2'd1,
        HALT   = 2'd2
    } state_t;

    state_t       state;
    logic [N-1:0] model_next;
    logic [2:0]   mism;

    // next model value follows the counter's own priority: reset, load, count
    always_comb begin
        model_next = exp_q;
        if (obs.dut_rst) begin
            model_next = '0;
        end else if (obs.dut_load) begin
            model_next = obs.dut_D;
        end else if (obs.dut_en) begin
            model_next = obs.dut_up ? exp_q + N'(1) : exp_q - N'(1);
        end
    end

    // mismatch bits against the pre-edge expectation: {min, max, Q}
    always_comb begin
        mism = {obs.dut_min_tick != (exp_q == '0),
                obs.dut_max_tick != (exp_q == '1),
                obs.dut_Q != exp_q};
    end

    // sync / track / halt sequencing with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= UNSYNC;
            synced      <= 1'b0;
            err         <= 1'b0;
            err_sticky  <= 1'b0;
            err_code    <= 3'b000;
            err_count   <= '0;
            exp_q       <= '0;
            first_bad_q <= '0;
        end else begin
            case (state)
                UNSYNC: begin
                    err      <= 1'b0;
                    err_code <= 3'b000;
                    // only a reset or load gives a known counter value to lock onto
                    if (obs.dut_rst || obs.dut_load) begin
                        exp_q  <= model_next;
                        state  <= TRACK;
                        synced <= 1'b1;
                    end
                end
                TRACK: begin
                    synced   <= 1'b1;
                    err      <= |mism;
                    err_code <= mism;
                    // model keeps following the counter inputs, never resyncs to Q
                    exp_q    <= model_next;
                    if (|mism) begin
                        if (err_count != '1) begin
                            err_count <= err_count + CW'(1);
                        end
                        if (!err_sticky) begin
                            first_bad_q <= obs.dut_Q;
                        end
                        err_sticky <= 1'b1;
                        if (STOP_ON_ERR != 0) begin
                            state <= HALT;
                        end
                    end
                end
                HALT: begin
                    synced <= 1'b1;
                    err    <= 1'b0;
                end
                default: begin
                    state <= UNSYNC;
                end
            endcase
        end
    end

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Synthesizable on-chip monitor that observes an N-bit up/down loadable counter's control inputs and outputs.
- Keeps a cycle-accurate reference model of the counter, compares it against the counter's Q, max_tick and min_tick every clock, and reports mismatches.
- Sits beside the counter in FPGA lab builds as the hardware counterpart of the simulation self-check: errors drive LEDs, and the count is read out.

Parameters:
- N, 5, counter width in bits (must match the observed counter).
- CW, 8, width of the error counter.
- STOP_ON_ERR, 0, 1 = freeze the model and capture registers at the first error.

Ports:
- clk  in  1  system clock, shared with the observed counter.
- rst  in  1  checker reset, synchronous, active-high; clears all checker state.
- dut_rst  in  1  observed counter's reset.
- dut_load  in  1  observed load.
- dut_en  in  1  observed enable.
- dut_up  in  1  observed direction (1 = up).
- dut_D  in  N  observed load data.
- dut_Q  in  N  observed counter output.
- dut_max_tick  in  1  observed max tick.
- dut_min_tick  in  1  observed min tick.
- synced  out  1  model is tracking the counter.
- err  out  1  one-cycle error pulse.
- err_sticky  out  1  set on first error; cleared only by rst.
- err_code  out  3  bit0 = Q mismatch, bit1 = max_tick mismatch, bit2 = min_tick mismatch; valid with err.
- err_count  out  CW  number of error cycles, saturating at 2^CW-1.
- exp_q  out  N  model value (current expectation).
- first_bad_q  out  N  dut_Q captured at the first error.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous, active-high.
- Reset values (rst=1 at a rising edge): synced=0, err=0, err_sticky=0, err_code=0, err_count=0, exp_q=0, first_bad_q=0, state=UNSYNC. rst overrides every other input.
- Model update, evaluated on each rising edge, priority order:
  - dut_rst=1: exp_q <= 0.
  - else dut_load=1: exp_q <= dut_D.
  - else dut_en=1 and dut_up=1: exp_q <= exp_q+1, mod 2^N.
  - else dut_en=1 and dut_up=0: exp_q <= exp_q-1, mod 2^N.
  - else hold.
- Wrap-around: 2^N-1 +1 -> 0; 0 -1 -> 2^N-1. Arithmetic is N bits with the carry discarded.
- Expected ticks (combinational from exp_q): max = (exp_q == 2^N-1), min = (exp_q == 0).
- FSM:
  - UNSYNC: no comparison is made. dut_rst=1 or dut_load=1 at an edge loads the model as above and moves to TRACK. synced=0.
  - TRACK: synced=1. Each edge, compare dut_Q vs exp_q, dut_max_tick vs expected max, and dut_min_tick vs expected min, using values present before the edge. Any mismatch on that edge produces, the next cycle:
    - err=1;
    - err_code set to the mismatch bits;
    - err_count incremented (holds at max);
    - err_sticky=1;
    - first_bad_q <= dut_Q, only if err_sticky was 0.
    - After the mismatch: if STOP_ON_ERR=1, go to HALT; otherwise stay in TRACK and keep following the dut inputs, without resyncing to dut_Q.
  - HALT: exp_q, err_count and first_bad_q frozen. err=0. synced stays 1. Exit only via rst.
- Latency: a mismatch on dut signals sampled at edge k is visible on err after edge k. err is 0 on every cycle without a mismatch.
- Simultaneous events:
  - A mismatch and a dut_rst/dut_load on the same edge: the comparison uses the old exp_q, and the model then loads the new value.
  - err_count saturating and a new error on the same edge: err still pulses and the count holds.
- dut_rst held for several cycles: exp_q stays 0 and comparison continues; Q must read 0 from the second edge onward.
- rst mid-operation: full return to UNSYNC. No error is reported on the reset edge.

Test Plan (N=5, CW=8, behavioural correct counter unless stated):
- rst, then dut_rst pulse, then en=1, up=1 for 40 cycles -> synced=1, err never asserted, exp_q=8, wraps 31->0 with dut_max_tick checked at 31.
- Load D=0x03, en=1, up=0 for 5 cycles -> exp_q=0x1E (0x03-5 mod 32), min_tick expected exactly at the cycle with Q=0, err_count=0.
- Fault injection: force dut_Q bit0 inverted for one cycle while exp_q=0x0A -> err=1 for one cycle, err_code=3'b001, err_count=1, err_sticky=1, first_bad_q=0x0B.
- Tie dut_max_tick=0 and count up through 31 with STOP_ON_ERR=1 -> err_code=3'b010, state HALT, exp_q frozen at 0x00, later faults do not change err_count=1.
- Before any dut_rst/load, drive a garbage Q with en toggling -> synced=0, err stays 0. Then dut_load D=0x11 -> synced=1, tracking from 0x11.
- Inject 300 error cycles with STOP_ON_ERR=0 -> err_count saturates at 255. Assert rst mid-count -> all outputs return to reset values on the next edge.
